compressor_ring_sched: RTL and testbench
========================================

// Module: compressor_ring_sched
// PURPOSE
//  Job sequencer in front of compressor_ring: queues compression jobs (bitwidth, value count), programs ring config,
//  gates upstream samples into the ring for exactly job_count beats, then waits for the ring's last output beat.
//  Ring config is held stable for the whole job; next job starts back-to-back from the queue.
// PARAMETERS
//  DATA_W   16  sample width (ring rcv/trm data width)
//  BW_W     4   width of bitwidth_d code (effective bits = code+1)
//  CNT_W    32  width of job value count / transmitted_values
//  QDEPTH   4   job queue depth, power of 2, >=2
//  TIMEOUT  1024 drain watchdog limit in cycles (only with COMPRESSOR_SCHED_TIMEOUT_EN)
// PORTS
//  clk                   in  1       clock, all logic rising-edge
//  rst                   in  1       synchronous reset, active-high
//  job_valid             in  1       job descriptor valid
//  job_bitwidth          in  BW_W    bitwidth code for job
//  job_count             in  CNT_W   number of samples in job
//  job_ready             out 1       queue not full
//  in_valid / in_data    in  1/DATA_W upstream sample stream
//  in_ready              out 1       upstream accept
//  cr_bitwidth_d         out BW_W    ring bitwidth config
//  cr_mask_valid_bits    out DATA_W  ring mask = (code+1) LSBs set
//  cr_transmitted_values out CNT_W   ring value count config
//  cr_rcv_valid/_data    out 1/DATA_W samples into ring
//  cr_rcv_ready          in  1       ring accepts sample
//  cr_trm_valid/_ready/_last in 1/1/1 ring output handshake (monitored only)
//  busy                  out 1       FSM not IDLE
//  job_done              out 1       1-cycle pulse per completed job
//  jobs_completed        out 16      wrapping completed-job counter
//  err_zero_len          out 1       1-cycle pulse: job_count==0 dropped
//  err_timeout           out 1       sticky drain timeout flag
// BEHAVIOUR
//  - Reset: all outputs 0, queue empty, FSM IDLE, job_ready=1 only from first cycle after rst deasserts.
//  - Queue push on job_valid&job_ready; push into full queue impossible (job_ready=0). Push+pop same cycle legal when full.
//  - FSM: IDLE -> LOAD when queue non-empty (pop). LOAD: latch config, drive cr_* config outputs, 1 cycle, no samples.
//    LOAD -> DONE if count==0 (err_zero_len pulse), else STREAM.
//    STREAM: cr_rcv_valid=in_valid, in_ready=cr_rcv_ready, cr_rcv_data=in_data (combinational pass, zero latency);
//    beat = in_valid&cr_rcv_ready; beat counter increments; on beat with counter==count-1 -> DRAIN same edge.
//    Outside STREAM: in_ready=0, cr_rcv_valid=0.
//    DRAIN: wait cr_trm_valid&cr_trm_ready&cr_trm_last -> DONE. DONE: job_done=1, jobs_completed++,
//    -> LOAD if queue non-empty else IDLE (back-to-back: one DONE + one LOAD cycle between jobs).
//  - Config outputs change only in LOAD; held through DONE; retained (not cleared) in IDLE.
//  - trm last seen during STREAM (early) is ignored; only DRAIN terminates.
//  - Mask: code 15 -> 16'hFFFF; code 3 -> 16'h000F. Count compare full CNT_W, no wrap.
//  - rst mid-job: FSM to IDLE, queue flushed, counters cleared, in_ready/cr_rcv_valid low next cycle; ring is reset by same rst.
// CONFIGURATION
//  COMPRESSOR_SCHED_TIMEOUT_EN defined: DRAIN cycle counter; reaching TIMEOUT sets err_timeout (sticky until rst)
//    and forces DONE (job_done still pulses). Counter cleared on entering DRAIN.
//  Not defined: DRAIN waits indefinitely; err_timeout tied 0; no counter logic.
// STRUCTURE
//  Package compressor_pkg: sched_state_e {IDLE,LOAD,STREAM,DRAIN,DONE}, typedef struct job_t {bitwidth,count},
//    localparam default widths, function bw_to_mask(code).
//  Sub-module sched_job_fifo (job_t, QDEPTH): sync FIFO, full/empty, registered outputs; FSM+counters in top.
// TESTING
//  1 job bw=3 count=4, in_valid always 1, ring ready 1 -> config 3/0x000F/4 in LOAD, exactly 4 beats, DRAIN, job_done 1 pulse.
//  2 Two queued jobs (3,4),(7,2) -> second LOAD 1 cycle after first DONE, config switches to 7/0x00FF/2, jobs_completed=2.
//  3 count=0 job -> err_zero_len pulse, no rcv_valid, job_done pulses, jobs_completed=1.
//  4 cr_rcv_ready toggling 1010 with count=4 -> 8 STREAM cycles, in_ready mirrors ring ready, no lost/extra beat.
//  5 Push 5 jobs QDEPTH=4 with FSM stalled in DRAIN -> job_ready=0 after 4th queued; 5th held by producer.
//  6 rst asserted in STREAM after 2 beats -> next cycle busy=0, in_ready=0, queue empty; TIMEOUT_EN: no last -> err_timeout at 1024.

Source files
------------

// File: rtl/compressor_pkg.sv
// Shared types for the compressor ring job sequencer: FSM states, the queued
// job descriptor, default widths and the bitwidth-code to mask helper.
package compressor_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int BW_W_DEF   = 4;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } sched_state_e;

    typedef struct packed {
        logic [BW_W_DEF-1:0]  bitwidth;
        logic [CNT_W_DEF-1:0] count;
    } job_t;

    // Effective bit count is code+1, so the mask has code+1 LSBs set.
    function automatic logic [DATA_W_DEF-1:0] bw_to_mask(input logic [BW_W_DEF-1:0] code);
        logic [DATA_W_DEF:0] ones;
        ones = ((DATA_W_DEF + 1)'(1) << (int'(code) + 1)) - (DATA_W_DEF + 1)'(1);
        return ones[DATA_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// Synchronous show-ahead job queue. The ready (not full) and empty flags are
// registered; ready stays low while rst is held and rises on the first edge
// after release. A push into a full queue is accepted only alongside a pop.
module sched_job_fifo
    import compressor_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  job_t push_data,
    output logic ready,
    input  logic pop,
    output job_t pop_data,
    output logic empty
);

    localparam int AW = $clog2(QDEPTH);

    job_t             mem [QDEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != (AW + 1)'(QDEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        // NOTE: default assigned first so every path drives count_next; no latch.
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    // Storage write; contents are only read once the occupancy says valid.
    always_ff @(posedge clk) begin
        // NOTE: storage array is deliberately not reset; pointers and count guard it.
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            empty <= (count_next == '0);
            ready <= (count_next != (AW + 1)'(QDEPTH));
        end
    end

endmodule

// File: rtl/compressor_ring_sched.sv
// Job sequencer in front of compressor_ring. Pops queued jobs, programs the
// ring config for the whole job, passes exactly job_count samples through and
// then waits for the ring's last output beat.
// Optional drain watchdog: define COMPRESSOR_SCHED_TIMEOUT_EN.
// Width parameters must match the package defaults used by job_t.
module compressor_ring_sched
    import compressor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BW_W   = BW_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int QDEPTH = 4
`ifdef COMPRESSOR_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    input  logic [BW_W-1:0]   job_bitwidth,
    input  logic [CNT_W-1:0]  job_count,
    output logic              job_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [BW_W-1:0]   cr_bitwidth_d,
    output logic [DATA_W-1:0] cr_mask_valid_bits,
    output logic [CNT_W-1:0]  cr_transmitted_values,
    output logic              cr_rcv_valid,
    output logic [DATA_W-1:0] cr_rcv_data,
    input  logic              cr_rcv_ready,
    input  logic              cr_trm_valid,
    input  logic              cr_trm_ready,
    input  logic              cr_trm_last,
    output logic              busy,
    output logic              job_done,
    output logic [15:0]       jobs_completed,
    output logic              err_zero_len,
    output logic              err_timeout
);

    sched_state_e     state;
    sched_state_e     state_next;
    job_t             push_job;
    job_t             head_job;
    logic             fifo_empty;
    logic             pop;
    logic             streaming;
    logic             beat;
    logic             trm_done;
    logic             drain_exit;
    logic [CNT_W-1:0] beat_cnt;

    assign push_job.bitwidth = job_bitwidth;
    assign push_job.count    = job_count;

    sched_job_fifo #(
        .QDEPTH    (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (job_valid && job_ready),
        .push_data (push_job),
        .ready     (job_ready),
        .pop       (pop),
        .pop_data  (head_job),
        .empty     (fifo_empty)
    );

    assign streaming    = (state == STREAM);
    assign beat         = streaming && in_valid && cr_rcv_ready;
    assign trm_done     = cr_trm_valid && cr_trm_ready && cr_trm_last;

    // Zero-latency sample path, closed outside STREAM.
    assign in_ready     = streaming && cr_rcv_ready;
    assign cr_rcv_valid = streaming && in_valid;
    assign cr_rcv_data  = streaming ? in_data : '0;

    assign busy         = (state != IDLE);
    assign job_done     = (state == DONE);
    assign err_zero_len = (state == LOAD) && (cr_transmitted_values == '0);

`ifdef COMPRESSOR_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] drain_cnt;
    logic          timeout_hit;

    assign timeout_hit = (state == DRAIN) && !trm_done && (drain_cnt == TW'(TIMEOUT - 1));
    assign drain_exit  = trm_done || timeout_hit;

    // Drain watchdog: counts DRAIN cycles, cleared whenever outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst || state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + TW'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (timeout_hit) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign drain_exit  = trm_done;
    assign err_timeout = 1'b0;
`endif

    // Next-state and queue pop decision.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = (cr_transmitted_values == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (beat && (beat_cnt == cr_transmitted_values - CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_exit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ring config: loaded on the pop edge so it is valid from LOAD onwards and
    // retained after the job ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            cr_bitwidth_d         <= '0;
            cr_mask_valid_bits    <= '0;
            cr_transmitted_values <= '0;
        end else if (pop) begin
            cr_bitwidth_d         <= head_job.bitwidth;
            cr_mask_valid_bits    <= bw_to_mask(head_job.bitwidth);
            cr_transmitted_values <= head_job.count;
        end
    end

    // Beat counter for the current job, restarted in LOAD.
    always_ff @(posedge clk) begin
        if (rst || state == LOAD) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Wrapping completed-job counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_completed <= '0;
        end else if (state == DONE) begin
            jobs_completed <= jobs_completed + 16'd1;
        end
    end

endmodule

// File: tb/tb_compressor_ring_sched.sv
// Self-checking bench for compressor_ring_sched: reset values, a table of
// single-job vectors, hand-written multi-cycle sequences (back-to-back jobs,
// full queue, reset mid-stream, optional drain timeout) and a randomized run
// scored against a transaction-level job queue model.
module tb_compressor_ring_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic [3:0]  job_bitwidth;
    logic [31:0] job_count;
    logic        job_ready;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  cr_bitwidth_d;
    logic [15:0] cr_mask_valid_bits;
    logic [31:0] cr_transmitted_values;
    logic        cr_rcv_valid;
    logic [15:0] cr_rcv_data;
    logic        cr_rcv_ready;
    logic        cr_trm_valid;
    logic        cr_trm_ready;
    logic        cr_trm_last;
    logic        busy;
    logic        job_done;
    logic [15:0] jobs_completed;
    logic        err_zero_len;
    logic        err_timeout;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int exp_jc     = 0;

    compressor_ring_sched dut (
        .clk                   (clk),
        .rst                   (rst),
        .job_valid             (job_valid),
        .job_bitwidth          (job_bitwidth),
        .job_count             (job_count),
        .job_ready             (job_ready),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_ready              (in_ready),
        .cr_bitwidth_d         (cr_bitwidth_d),
        .cr_mask_valid_bits    (cr_mask_valid_bits),
        .cr_transmitted_values (cr_transmitted_values),
        .cr_rcv_valid          (cr_rcv_valid),
        .cr_rcv_data           (cr_rcv_data),
        .cr_rcv_ready          (cr_rcv_ready),
        .cr_trm_valid          (cr_trm_valid),
        .cr_trm_ready          (cr_trm_ready),
        .cr_trm_last           (cr_trm_last),
        .busy                  (busy),
        .job_done              (job_done),
        .jobs_completed        (jobs_completed),
        .err_zero_len          (err_zero_len),
        .err_timeout           (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  bw;
        logic [31:0] cnt;
        logic [31:0] rdy_pat;     // cr_rcv_ready per STREAM cycle (bit i = cycle i)
        logic [15:0] exp_mask;
        int          exp_stream;  // STREAM cycles expected
        int          exp_zl;      // err_zero_len pulses expected
    } vec_t;

    typedef struct {
        logic [3:0]  bw;
        logic [31:0] cnt;
    } mjob_t;

    vec_t  vecs [6];
    mjob_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_mask(input int bw);
        int m = 0;
        for (int i = 0; i <= bw; i++) m = m | (1 << i);
        return m;
    endfunction

    // Called at a falling edge; returns at the falling edge after the push edge.
    task automatic push_job(input logic [3:0] bw, input logic [31:0] cnt);
        int waited = 0;
        job_valid    = 1'b1;
        job_bitwidth = bw;
        job_count    = cnt;
        #1;
        while (!job_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("push accepted", job_ready, 1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int beats = 0, scyc = 0, zl = 0, dones = 0, mirror_err = 0, data_err = 0;
        logic seen_busy = 1'b0;
        logic [3:0]  load_bw = '0;
        logic [15:0] load_mask = '0;
        logic [31:0] load_cnt = '0;
        logic        load_stream = 1'b0;
        in_valid     = 1'b1;
        cr_trm_valid = 1'b1;
        cr_trm_ready = 1'b1;
        cr_trm_last  = 1'b1;   // early last during STREAM must be ignored
        push_job(v.bw, v.cnt);
        for (int c = 0; c < 100; c++) begin
            cr_rcv_ready = (scyc < 32) ? v.rdy_pat[scyc] : 1'b1;
            in_data      = 16'($urandom);
            #1;
            if (busy && !seen_busy) begin
                seen_busy   = 1'b1;
                load_bw     = cr_bitwidth_d;
                load_mask   = cr_mask_valid_bits;
                load_cnt    = cr_transmitted_values;
                load_stream = cr_rcv_valid;
            end
            if (cr_rcv_valid) begin
                scyc++;
                if (in_ready !== cr_rcv_ready) mirror_err++;
                if (cr_rcv_ready) begin
                    beats++;
                    if (cr_rcv_data !== in_data) data_err++;
                end
            end
            if (err_zero_len) zl++;
            if (job_done) dones++;
            if (dones > 0 && !busy) break;
            @(negedge clk);
        end
        check("vec load bitwidth", load_bw, v.bw);
        check("vec load mask", load_mask, v.exp_mask);
        check("vec load count", load_cnt, v.cnt);
        check("vec no sample in load", load_stream, 0);
        check("vec stream cycles", scyc, v.exp_stream);
        check("vec beats", beats, v.cnt);
        check("vec zero-len pulses", zl, v.exp_zl);
        check("vec job_done pulses", dones, 1);
        check("vec in_ready mirror errors", mirror_err, 0);
        check("vec data errors", data_err, 0);
        exp_jc++;
        check("vec jobs_completed", jobs_completed, exp_jc);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd3,  32'd4, 32'hFFFF_FFFF, 16'h000F, 4, 0};
        vecs[1] = '{4'd15, 32'd1, 32'hFFFF_FFFF, 16'hFFFF, 1, 0};
        vecs[2] = '{4'd7,  32'd2, 32'hFFFF_FFFF, 16'h00FF, 2, 0};
        vecs[3] = '{4'd3,  32'd4, 32'hAAAA_AAAA, 16'h000F, 8, 0};
        vecs[4] = '{4'd0,  32'd3, 32'h3333_3333, 16'h0001, 5, 0};
        vecs[5] = '{4'd9,  32'd0, 32'hFFFF_FFFF, 16'h03FF, 0, 1};

        rst = 1'b1; job_valid = 0; job_bitwidth = 0; job_count = 0;
        in_valid = 0; in_data = 16'hA5A5; cr_rcv_ready = 0;
        cr_trm_valid = 0; cr_trm_ready = 0; cr_trm_last = 0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("reset job_ready", job_ready, 0);
        check("reset busy", busy, 0);
        check("reset cfg bitwidth", cr_bitwidth_d, 0);
        check("reset cfg mask", cr_mask_valid_bits, 0);
        check("reset cfg count", cr_transmitted_values, 0);
        check("reset jobs_completed", jobs_completed, 0);
        check("reset err_timeout", err_timeout, 0);
        check("reset rcv_data", cr_rcv_data, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("job_ready before first edge", job_ready, 0);
        @(negedge clk);
        #1;
        check("job_ready after reset release", job_ready, 1);
        @(negedge clk);

        // ---------------- table-driven single jobs ----------------
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // ---------------- back-to-back jobs ----------------
        begin
            int first_done = -1, dones = 0;
            in_valid = 1; cr_rcv_ready = 1;
            cr_trm_valid = 1; cr_trm_ready = 1; cr_trm_last = 1;
            push_job(4'd3, 32'd4);
            push_job(4'd7, 32'd2);
            for (int c = 0; c < 60; c++) begin
                in_data = 16'($urandom);
                #1;
                if (job_done) begin
                    dones++;
                    if (first_done < 0) begin
                        first_done = c;
                        check("b2b cfg held in done", cr_bitwidth_d, 3);
                    end
                end
                if (first_done >= 0 && c == first_done + 1) begin
                    check("b2b second load bitwidth", cr_bitwidth_d, 7);
                    check("b2b second load mask", cr_mask_valid_bits, 16'h00FF);
                    check("b2b second load count", cr_transmitted_values, 2);
                    check("b2b load not streaming", cr_rcv_valid, 0);
                    check("b2b busy in load", busy, 1);
                end
                if (first_done >= 0 && c == first_done + 2)
                    check("b2b stream after load", cr_rcv_valid, 1);
                if (dones == 2 && !busy) break;
                @(negedge clk);
            end
            check("b2b job_done pulses", dones, 2);
            exp_jc += 2;
            check("b2b jobs_completed", jobs_completed, exp_jc);
            @(negedge clk);
        end

        // ---------------- full queue while stalled in DRAIN ----------------
        begin
            int dones = 0, acc = 0, ready_seen = 0;
            logic clear_valid;
            cr_trm_last = 0;
            push_job(4'd1, 32'd1);
            repeat (8) @(negedge clk);
            #1;
            check("stall busy", busy, 1);
            check("stall no samples", cr_rcv_valid, 0);
            @(negedge clk);
            for (int i = 0; i < 4; i++) push_job(4'd2, 32'd1);
            #1;
            check("full after 4 queued", job_ready, 0);
            @(negedge clk);
            job_valid = 1; job_bitwidth = 4'd5; job_count = 32'd2;
            for (int c = 0; c < 5; c++) begin
                #1;
                if (job_ready) ready_seen++;
                @(negedge clk);
            end
            check("fifth held while full", ready_seen, 0);
            cr_trm_last = 1;
            for (int c = 0; c < 200; c++) begin
                #1;
                clear_valid = 1'b0;
                if (job_valid && job_ready) begin
                    acc++;
                    clear_valid = 1'b1;
                end
                if (job_done) dones++;
                if (dones == 6 && !busy) break;
                @(negedge clk);
                if (clear_valid) job_valid = 0;
            end
            check("fifth accepted once", acc, 1);
            check("stall job_done pulses", dones, 6);
            exp_jc += 6;
            check("stall jobs_completed", jobs_completed, exp_jc);
            @(negedge clk);
        end

        // ---------------- reset mid-stream ----------------
        begin
            int beats = 0, busy_seen = 0;
            cr_trm_last = 0; cr_rcv_ready = 1; in_valid = 1;
            push_job(4'd2, 32'd10);
            push_job(4'd5, 32'd3);
            for (int c = 0; c < 50; c++) begin
                #1;
                if (cr_rcv_valid && cr_rcv_ready) beats++;
                if (beats == 2) break;
                @(negedge clk);
            end
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("rst busy", busy, 0);
            check("rst in_ready", in_ready, 0);
            check("rst rcv_valid", cr_rcv_valid, 0);
            check("rst rcv_data", cr_rcv_data, 0);
            check("rst job_ready", job_ready, 0);
            check("rst jobs_completed", jobs_completed, 0);
            check("rst cfg count", cr_transmitted_values, 0);
            @(negedge clk);
            rst = 1'b0;
            exp_jc = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                #1;
                if (busy) busy_seen++;
            end
            check("queue flushed by rst", busy_seen, 0);
            check("job_ready after rst", job_ready, 1);
            @(negedge clk);
        end

        // ---------------- randomized run vs job-queue model ----------------
        begin
            int beats = 0, zl = 0, m_done = 0;
            mjob_t j;
            for (int c = 0; c < 3000; c++) begin
                job_valid    = (c < 2500) && ($urandom % 4 == 0);
                job_bitwidth = 4'($urandom);
                job_count    = 32'($urandom % 6);
                in_valid     = ($urandom % 4 != 0);
                in_data      = 16'($urandom);
                cr_rcv_ready = ($urandom % 4 != 0);
                cr_trm_valid = 1'($urandom);
                cr_trm_ready = 1'($urandom);
                cr_trm_last  = 1'($urandom);
                #1;
                if (job_valid && job_ready) exp_q.push_back('{job_bitwidth, job_count});
                if (cr_rcv_valid && cr_rcv_ready) begin
                    beats++;
                    check("rand beat data", cr_rcv_data, in_data);
                    if (exp_q.size() > 0) begin
                        check("rand beat cfg bitwidth", cr_bitwidth_d, exp_q[0].bw);
                        check("rand beat cfg count", cr_transmitted_values, exp_q[0].cnt);
                    end
                end
                if (err_zero_len) zl++;
                if (job_done) begin
                    check("rand job pending at done", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        j = exp_q.pop_front();
                        check("rand beats per job", beats, j.cnt);
                        check("rand cfg bitwidth", cr_bitwidth_d, j.bw);
                        check("rand cfg mask", cr_mask_valid_bits, ref_mask(int'(j.bw)));
                        check("rand cfg count", cr_transmitted_values, j.cnt);
                        check("rand zero-len pulse", zl, (j.cnt == 0) ? 1 : 0);
                        check("rand jobs_completed", jobs_completed, m_done & 16'hFFFF);
                        m_done++;
                    end
                    beats = 0;
                    zl = 0;
                end
                @(negedge clk);
            end
            #1;
            check("rand model queue drained", exp_q.size(), 0);
            check("rand idle at end", busy, 0);
            check("rand total jobs", jobs_completed, m_done & 16'hFFFF);
            @(negedge clk);
        end

`ifdef COMPRESSOR_SCHED_TIMEOUT_EN
        // ---------------- drain timeout ----------------
        begin
            int drain_cyc = 0;
            logic after_beat = 1'b0;
            logic done_seen = 1'b0;
            job_valid = 0; in_valid = 1; cr_rcv_ready = 1;
            cr_trm_valid = 1; cr_trm_ready = 1; cr_trm_last = 0;
            push_job(4'd0, 32'd1);
            for (int c = 0; c < 1200; c++) begin
                #1;
                if (job_done) begin
                    done_seen = 1'b1;
                    check("timeout flag at done", err_timeout, 1);
                    break;
                end
                if (after_beat) begin
                    drain_cyc++;
                    if (drain_cyc == 1024) check("timeout flag low in drain", err_timeout, 0);
                end
                if (cr_rcv_valid && cr_rcv_ready) after_beat = 1'b1;
                @(negedge clk);
            end
            check("timeout job_done", done_seen, 1);
            check("timeout drain cycles", drain_cyc, 1024);
            repeat (3) @(negedge clk);
            #1;
            check("timeout flag sticky", err_timeout, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
